// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external full-adder cell LSB first to add a + b + cin.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E_WIDTH; one result per WIDTH+1 cycles.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored (not queued) while busy.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   start, a, b, cin          : request and operands, captured on the accepting edge
//   fa_a, fa_b, fa_cin        : bit pair and running carry presented to the full-adder cell
//   fa_sum, fa_carry          : combinational results returned by the cell
//   sum, cout                 : registered result, updated only on entry to DONE
//   busy, done                : busy while shifting, done is a one-cycle completion pulse
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last_bit  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        fa_a   = a_reg[0];
        fa_b   = b_reg[0];
        fa_cin = carry_reg;
        if (cnt == LAST) begin
          state_nxt = DONE;
          last_bit  = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back: a start seen during the done cycle reloads immediately.
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (load) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      res_reg   <= '0;
      cnt       <= '0;
    end else if (state == SHIFT) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
      res_reg   <= {fa_sum, res_reg[WIDTH-1:1]};
      carry_reg <= fa_carry;
      cnt       <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= {fa_sum, res_reg[WIDTH-1:1]};
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  typedef struct {
    logic [32:0] res;
    int          edge_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount++;

  int checks = 0;
  int errors = 0;

  // ---------------- WIDTH=8 instance ----------------
  logic       rst8_n, start8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_carry8, cout8, busy8, done8;

  // full-adder cell
  assign fa_sum8   = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_carry8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_carry(fa_carry8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic       rst4_n, start4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       fa_a4, fa_b4, fa_cin4, fa_sum4, fa_carry4, cout4, busy4, done4;

  assign fa_sum4   = fa_a4 ^ fa_b4 ^ fa_cin4;
  assign fa_carry4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_sum(fa_sum4), .fa_carry(fa_carry4),
    .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
  );

  // ---------------- reference model state ----------------
  // An operation accepted at edge k occupies the block until the done cycle;
  // the next start is accepted from edge k+WIDTH+1 onwards.
  exp_t q8[$];
  exp_t q4[$];
  int   free8 = 0;
  int   free4 = 0;
  int   pushed8 = 0;
  int   pushed4 = 0;
  logic prev_done8 = 1'b0;
  logic prev_done4 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, ecount);
    end
  endtask

  task automatic drive8(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    exp_t e;
    @(posedge clk);
    #1;
    start8 = s; a8 = av; b8 = bv; cin8 = cv;
    if (s && rst8_n && (ecount + 1 >= free8)) begin
      e.res    = 33'(av) + 33'(bv) + 33'(cv);
      e.edge_n = ecount + 1 + 8;
      q8.push_back(e);
      free8 = ecount + 2 + 8;
      pushed8++;
    end
  endtask

  task automatic drive4(input logic s, input logic [3:0] av, input logic [3:0] bv, input logic cv);
    exp_t e;
    @(posedge clk);
    #1;
    start4 = s; a4 = av; b4 = bv; cin4 = cv;
    if (s && rst4_n && (ecount + 1 >= free4)) begin
      e.res    = 33'(av) + 33'(bv) + 33'(cv);
      e.edge_n = ecount + 1 + 4;
      q4.push_back(e);
      free4 = ecount + 2 + 4;
      pushed4++;
    end
  endtask

  task automatic wait_empty8();
    for (int k = 0; k < 200 && q8.size() != 0; k++) @(posedge clk);
    if (q8.size() != 0) chk("timeout8_pending", 64'(q8.size()), 64'd0);
  endtask

  task automatic wait_empty4();
    for (int k = 0; k < 200 && q4.size() != 0; k++) @(posedge clk);
    if (q4.size() != 0) chk("timeout4_pending", 64'(q4.size()), 64'd0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        chk("result8", 64'({cout8, sum8}), 64'(e.res[8:0]));
        chk("done8_edge", 64'(ecount), 64'(e.edge_n));
      end
      chk("done8_single_cycle", 64'(prev_done8), 64'd0);
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 64'd1, 64'd0);
      end else begin
        e = q4.pop_front();
        chk("result4", 64'({cout4, sum4}), 64'(e.res[4:0]));
        chk("done4_edge", 64'(ecount), 64'(e.edge_n));
      end
      chk("done4_single_cycle", 64'(prev_done4), 64'd0);
    end
    prev_done4 = done4;
  end

  // ---------------- stimulus ----------------
  task automatic seq8();
    logic [7:0] pat;
    int guard;
    // Directed: 0x5A + 0x3C, check the LSB-first bit stream and busy.
    pat = 8'h5A;
    drive8(1'b1, 8'h5A, 8'h3C, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fa_a_bit", 64'(fa_a8), 64'(pat[i]));
      chk("busy_shift", 64'(busy8), 64'd1);
    end
    @(negedge clk);
    chk("busy_done_cycle", 64'(busy8), 64'd0);
    wait_empty8();

    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty8();
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty8();

    // Start pulse mid-operation must be ignored.
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    repeat (3) drive8(1'b0, 8'h00, 8'h00, 1'b0);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty8();

    // Start held high: back-to-back operations every 9 cycles.
    repeat (30) drive8(1'b1, 8'h01, 8'h02, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty8();

    // Reset mid-operation clears outputs asynchronously and aborts.
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    repeat (4) drive8(1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    rst8_n = 1'b0;
    q8.delete();
    free8 = 0;
    #1;
    chk("rst_async_sum", 64'(sum8), 64'd0);
    chk("rst_async_cout", 64'(cout8), 64'd0);
    chk("rst_async_busy", 64'(busy8), 64'd0);
    chk("rst_async_fa", 64'({fa_a8, fa_b8, fa_cin8}), 64'd0);
    @(negedge clk);
    #2;
    rst8_n = 1'b1;
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty8();

    // Randomized traffic, including starts that land while busy.
    guard = 0;
    while (pushed8 < 1010 && guard < 30000) begin
      drive8($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
      guard++;
    end
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty8();
  endtask

  task automatic seq4();
    int guard;
    drive4(1'b1, 4'hF, 4'hF, 1'b1);
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    wait_empty4();
    guard = 0;
    while (pushed4 < 1001 && guard < 30000) begin
      drive4($urandom_range(0, 2) != 0, 4'($urandom), 4'($urandom), 1'($urandom));
      guard++;
    end
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    wait_empty4();
  endtask

  initial begin
    rst8_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst4_n = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #12;
    chk("reset_sum8", 64'(sum8), 64'd0);
    chk("reset_cout8", 64'(cout8), 64'd0);
    chk("reset_busy8", 64'(busy8), 64'd0);
    chk("reset_done8", 64'(done8), 64'd0);
    chk("reset_fa8", 64'({fa_a8, fa_b8, fa_cin8}), 64'd0);
    chk("reset_sum4", 64'({cout4, sum4}), 64'd0);
    #10;
    rst8_n = 1'b1;
    rst4_n = 1'b1;
    fork
      seq8();
      seq4();
    join
    repeat (3) @(posedge clk);
    chk("final_q8_empty", 64'(q8.size()), 64'd0);
    chk("final_q4_empty", 64'(q4.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that sequences the team's existing one-bit full-adder cell to add two WIDTH-bit operands over WIDTH clock cycles.
- Captures the operands on a start request, then feeds one bit pair plus the stored carry to the cell each cycle, LSB first.
- Collects the cell's sum and carry outputs into a result register and signals completion with a one-cycle done pulse.
- Sits between the lab's switch/register front end and the single full-adder cell, which is instantiated outside this block and connected via the fa_* ports.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on rising clk edge.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- fa_a  output  1  bit to the full-adder cell's a input.
- fa_b  output  1  bit to the full-adder cell's b input.
- fa_cin  output  1  carry to the full-adder cell's c input.
- fa_sum  input  1  sum bit returned by the cell (combinational).
- fa_carry  input  1  carry bit returned by the cell (combinational).
- sum  output  WIDTH  registered result; holds last completed value.
- cout  output  1  registered final carry-out.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout update.

Behaviour:
- Reset: asserting rst_n=0 immediately forces state=IDLE, sum=0, cout=0, busy=0, done=0, bit counter=0, internal shift/carry registers=0, fa_a=fa_b=fa_cin=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per cycle.
  - DONE: one cycle, done=1.
- IDLE -> SHIFT: on an edge with start=1. At that edge, a, b and cin load into the shift registers and carry register, and the counter is cleared.
- SHIFT:
  - Combinationally, fa_a=A_reg[0], fa_b=B_reg[0], fa_cin=carry_reg.
  - On each edge: fa_sum shifts into the MSB of the result shift register; A_reg and B_reg shift right by 1; carry_reg<=fa_carry; counter increments.
- SHIFT -> DONE: on the edge where counter==WIDTH-1, i.e. the WIDTH-th bit edge. At that same edge: sum<=completed result (including that edge's fa_sum), cout<=fa_carry.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 on that edge: go to SHIFT and load new operands (back-to-back).
  - Otherwise: go to IDLE.
- busy=1 only in SHIFT. fa_* outputs are 0 in IDLE and DONE.
- Latency: if start is accepted at edge E0, done is high in the cycle following edge E_WIDTH. Throughput is one result per WIDTH+1 cycles.
- Overlapping start: start=1 while in SHIFT is ignored. It is not queued, and the operands in flight are unaffected.
- Input stability: a, b and cin may change freely after the accepting edge.
- Output hold: sum and cout change only on entry to DONE (or on reset); they hold between operations.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No other flags.
- Reset mid-operation: aborts immediately; sum/cout clear to 0 and no done pulse is issued.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle -> busy high for 8 cycles, then done pulse, sum=0x96, cout=0; fa_a sequence LSB-first 0,1,0,1,1,0,1,0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start accepted with a=0x12, b=0x34; at bit 3, pulse start with a=0xFF, b=0xFF -> ignored; result sum=0x46, cout=0; done at the expected single cycle.
- Hold start=1 continuously with a=0x01, b=0x02 -> DONE goes directly to SHIFT; results sum=0x03 appear every 9 cycles; done never high for two consecutive cycles.
- Start a=0x80, b=0x80; drop rst_n to 0 at bit 4 -> outputs clear asynchronously (before the next edge), no done; after release, a new start with a=0x80, b=0x80 -> sum=0x00, cout=1.
- Bench connects the team's full-adder cell to the fa_* ports; randomized 1000-op compare against a+b+cin for WIDTH=8 and WIDTH=4.
